reaction_timer_ctrl: RTL and testbench
======================================

// Module: reaction_timer_ctrl
// PURPOSE
//   Game controller for the reaction-time tester. Drives the color1/bright1/color2/bright2 inputs of the RGB LED driver.
//   Arms on a start press, waits a pseudo-random delay, lights GO, and times the response press in milliseconds.
//   Reports early presses and timeouts as faults.
//   Sits between the debounced button pulses and the RGB LED driver.
// PARAMETERS
//   TICK_DIV      100000  clk cycles per 1 ms tick (100 MHz clk); benches use 10
//   MIN_DELAY_MS  1000    fixed part of the ARMED wait, in ms ticks
//   RAND_MASK     16'h07FF AND-mask on the LFSR value for the random part of the wait; 0 makes the wait deterministic
//   TIMEOUT_MS    2000    maximum time in GO; must be < 2^14
// PORTS
//   clk           in   1   system clock
//   rst           in   1   synchronous reset, active-high
//   start_btn     in   1   1-cycle pulse, already debounced
//   resp_btn      in   1   1-cycle pulse, already debounced
//   color1        out  3   LED1 colour code {B,G,R}
//   bright1       out  1   LED1 brightness: 1 = full, 0 = semi
//   color2        out  3   LED2 colour code {B,G,R}
//   bright2       out  1   LED2 brightness: 1 = full, 0 = semi
//   react_ms      out  14  last result in ms; holds until the next start
//   result_valid  out  1   1-cycle pulse on entry to DONE
//   early_fault   out  1   high while in FAULT caused by an early press
//   busy          out  1   high in ARMED or GO
// BEHAVIOUR
// - Colour codes: BLACK 000, RED 001, GREEN 010, BLUE 100, WHITE 111.
// - Reset (rst high at a clk edge): state IDLE, react_ms = 0, result_valid = 0, early_fault = 0.
//   Reset also clears the tick and ms counters and seeds the LFSR to 16'hACE1. Reset mid-game aborts the game immediately.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, including IDLE.
// - tick: pulse when the cycle counter reaches TICK_DIV-1, then the counter wraps to 0.
//   The cycle counter and the ms counter both clear on every state entry.
// - Moore outputs are decoded from the state register and change in the cycle after the transition edge.
//   State  LED1 (colour, bright)  LED2 (colour, bright)
//   IDLE   BLACK, 1               WHITE, 0
//   ARMED  RED, 0                 BLACK, 1
//   GO     GREEN, 1               BLACK, 1
//   DONE   BLUE, 1                GREEN, 1
//   FAULT  RED, 1                 RED, 1
// - IDLE -> ARMED on start_btn.
//   On that edge: delay = MIN_DELAY_MS + (lfsr & RAND_MASK) is latched (16-bit), react_ms and early_fault are cleared.
// - ARMED -> GO when the ms counter equals delay on a tick. ARMED lasts exactly delay*TICK_DIV cycles.
// - ARMED -> FAULT on resp_btn: early_fault = 1, react_ms = 0. resp_btn takes priority over a same-cycle GO transition.
// - GO -> DONE on resp_btn: react_ms = floor(k/TICK_DIV), where k = cycles since GO entry (entry cycle is k = 0).
// - GO -> FAULT when the ms counter reaches TIMEOUT_MS: react_ms = TIMEOUT_MS, early_fault = 0.
//   If resp_btn arrives on the same edge, resp_btn wins: DONE with react_ms = TIMEOUT_MS.
// - DONE/FAULT -> ARMED on start_btn, which starts a new game directly. All other inputs are ignored.
// - start_btn is ignored in ARMED/GO. resp_btn is ignored in IDLE/DONE/FAULT.
//   In IDLE, start_btn and resp_btn in the same cycle: start wins.
// - result_valid is high only in the first cycle of DONE. busy = (state == ARMED || state == GO).
// TESTING (TICK_DIV=10, MIN_DELAY_MS=5, RAND_MASK=0, TIMEOUT_MS=20)
// 1 Reset, then idle 20 cycles -> color1=000 bright1=1, color2=111 bright2=0, react_ms=0, busy=0.
// 2 start pulse -> color1=001 bright1=0 for exactly 50 cycles, then color1=010 bright1=1.
//   resp at k=37 -> DONE, react_ms=3, result_valid high 1 cycle, color1=100, color2=010.
// 3 start, then resp 20 cycles later (in ARMED) -> FAULT: early_fault=1, react_ms=0, color1=color2=001, bright1=bright2=1.
// 4 start, no resp -> FAULT after 200 GO cycles: react_ms=20, early_fault=0.
//   resp on the exact timeout edge instead -> DONE, react_ms=20.
// 5 start, wait 30 cycles in ARMED, assert rst -> IDLE outputs on the next cycle, busy=0, react_ms=0.
//   New start -> full 50-cycle ARMED wait.
// 6 start+resp same cycle in IDLE -> ARMED; start during GO ignored; start in DONE -> ARMED, react_ms cleared to 0.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
// rtl/reaction_timer_ctrl.sv - reaction-time game controller driving two RGB LED channels
//
// Purpose:
//   Arms on a start press, waits MIN_DELAY_MS plus a pseudo-random number of
//   ms ticks, lights GO, then times the response press in ms. A press while
//   armed, or no press within TIMEOUT_MS of GO, ends the game in FAULT.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   start_btn     debounced 1-cycle start pulse
//   resp_btn      debounced 1-cycle response pulse
//   color1/2      LED colour codes {B,G,R}
//   bright1/2     LED brightness, 1 = full, 0 = semi
//   react_ms      last result in ms, held until the next start
//   result_valid  1-cycle pulse in the first cycle of DONE
//   early_fault   high in FAULT when the fault was an early press
//   busy          high in ARMED or GO

module reaction_timer_ctrl #(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter logic [15:0] RAND_MASK    = 16'h07FF,
    parameter int unsigned TIMEOUT_MS   = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        resp_btn,
    output logic [2:0]  color1,
    output logic        bright1,
    output logic [2:0]  color2,
    output logic        bright2,
    output logic [13:0] react_ms,
    output logic        result_valid,
    output logic        early_fault,
    output logic        busy
);

    localparam int          CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [15:0] MIN_DELAY = 16'(MIN_DELAY_MS);
    localparam logic [15:0] TIMEOUT   = 16'(TIMEOUT_MS);
    localparam logic [13:0] TIMEOUT14 = 14'(TIMEOUT_MS);

    localparam logic [2:0] C_BLACK = 3'b000;
    localparam logic [2:0] C_RED   = 3'b001;
    localparam logic [2:0] C_GREEN = 3'b010;
    localparam logic [2:0] C_BLUE  = 3'b100;
    localparam logic [2:0] C_WHITE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_GO,
        S_DONE,
        S_FAULT
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [CW-1:0]  r_cyc;
    logic [15:0]    r_ms;
    logic [15:0]    r_delay;
    logic [15:0]    r_lfsr;
    logic [13:0]    r_react;
    logic           r_early;
    logic           r_result_valid;

    logic           w_tick;
    logic [15:0]    w_ms_inc;
    logic           w_lfsr_fb;
    logic           w_entry;
    logic           w_delay_hit;
    logic           w_timeout_hit;
    logic           w_load_game;
    logic           w_set_early;
    logic           w_done;
    logic           w_timeout;

    assign w_tick    = (r_cyc == TICK_LAST);
    assign w_ms_inc  = r_ms + 16'd1;
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_entry   = (w_state_next != r_state);

    // Compare against the value the ms counter is about to take, so the
    // transition lands exactly on the delay*TICK_DIV-th cycle of the state.
    assign w_delay_hit   = w_tick && (w_ms_inc == r_delay);
    assign w_timeout_hit = w_tick && (w_ms_inc == TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_game  = 1'b0;
        w_set_early  = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        color1       = C_BLACK;
        bright1      = 1'b1;
        color2       = C_WHITE;
        bright2      = 1'b0;
        busy         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_btn) begin
                    w_state_next = S_ARMED;
                    w_load_game  = 1'b1;
                end
            end
            S_ARMED: begin
                color1  = C_RED;
                bright1 = 1'b0;
                color2  = C_BLACK;
                bright2 = 1'b1;
                busy    = 1'b1;
                // An early press beats a GO transition on the same edge.
                if (resp_btn) begin
                    w_state_next = S_FAULT;
                    w_set_early  = 1'b1;
                end else if (w_delay_hit) begin
                    w_state_next = S_GO;
                end
            end
            S_GO: begin
                color1  = C_GREEN;
                bright1 = 1'b1;
                color2  = C_BLACK;
                bright2 = 1'b1;
                busy    = 1'b1;
                if (resp_btn) begin
                    w_state_next = S_DONE;
                    w_done       = 1'b1;
                end else if (w_timeout_hit) begin
                    w_state_next = S_FAULT;
                    w_timeout    = 1'b1;
                end
            end
            S_DONE: begin
                color1  = C_BLUE;
                bright1 = 1'b1;
                color2  = C_GREEN;
                bright2 = 1'b1;
                if (start_btn) begin
                    w_state_next = S_ARMED;
                    w_load_game  = 1'b1;
                end
            end
            S_FAULT: begin
                color1  = C_RED;
                bright1 = 1'b1;
                color2  = C_RED;
                bright2 = 1'b1;
                if (start_btn) begin
                    w_state_next = S_ARMED;
                    w_load_game  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr         <= 16'hACE1;
            r_cyc          <= '0;
            r_ms           <= '0;
            r_delay        <= '0;
            r_react        <= '0;
            r_early        <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_lfsr         <= {r_lfsr[14:0], w_lfsr_fb};
            r_result_valid <= w_done;

            // Both counters restart on every state entry so each state times
            // from its own first cycle.
            if (w_entry) begin
                r_cyc <= '0;
                r_ms  <= '0;
            end else if (w_tick) begin
                r_cyc <= '0;
                r_ms  <= w_ms_inc;
            end else begin
                r_cyc <= r_cyc + CW'(1);
            end

            if (w_load_game) begin
                r_delay <= MIN_DELAY + (r_lfsr & RAND_MASK);
                r_react <= '0;
                r_early <= 1'b0;
            end

            if (w_set_early) begin
                r_early <= 1'b1;
                r_react <= '0;
            end

            // A press on the timeout edge still counts as a response, but the
            // ms counter has not yet rolled over, so report the limit itself.
            if (w_done) begin
                r_react <= w_timeout_hit ? TIMEOUT14 : r_ms[13:0];
            end

            if (w_timeout) begin
                r_react <= TIMEOUT14;
                r_early <= 1'b0;
            end
        end
    end

    assign react_ms     = r_react;
    assign result_valid = r_result_valid;
    assign early_fault  = r_early;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb/tb_reaction_timer_ctrl.sv - scoreboard bench for reaction_timer_ctrl

module tb_reaction_timer_ctrl;

    logic        clk;
    logic        rst;
    logic        start_btn;
    logic        resp_btn;
    logic [2:0]  color1;
    logic        bright1;
    logic [2:0]  color2;
    logic        bright2;
    logic [13:0] react_ms;
    logic        result_valid;
    logic        early_fault;
    logic        busy;

    reaction_timer_ctrl #(
        .TICK_DIV     (10),
        .MIN_DELAY_MS (5),
        .RAND_MASK    (16'h0000),
        .TIMEOUT_MS   (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .resp_btn     (resp_btn),
        .color1       (color1),
        .bright1      (bright1),
        .color2       (color2),
        .bright2      (bright2),
        .react_ms     (react_ms),
        .result_valid (result_valid),
        .early_fault  (early_fault),
        .busy         (busy)
    );

    localparam int K_IDLE  = 0;
    localparam int K_DONE  = 1;
    localparam int K_FAULT = 2;

    typedef struct {
        string name;
        int    kind;
        int    react;
        int    early;
        int    armed;
        int    go;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input string name, input int kind, input int react,
                        input int early, input int armed, input int go);
        exp_t e;
        e.name  = name;
        e.kind  = kind;
        e.react = react;
        e.early = early;
        e.armed = armed;
        e.go    = go;
        sb.push_back(e);
    endtask

    // Monitor: measures ARMED/GO durations from the LED outputs and checks a
    // scoreboard entry every time the game leaves the busy states.
    int prev_busy = 0;
    int armed_cnt = 0;
    int go_cnt    = 0;
    int rv_follow = 0;

    always @(negedge clk) begin
        exp_t e;
        int   b;
        int   ec1, eb1, ec2, eb2;
        b = (busy === 1'b1) ? 1 : 0;
        if (rv_follow != 0) begin
            chk("result_valid_single_cycle", int'(result_valid), 0);
            rv_follow = 0;
        end
        if (b == 1 && prev_busy == 0) begin
            armed_cnt = 0;
            go_cnt    = 0;
        end
        if (b == 1 && color1 == 3'b001 && bright1 == 1'b0) armed_cnt++;
        if (b == 1 && color1 == 3'b010 && bright1 == 1'b1) go_cnt++;
        if (b == 0 && prev_busy == 1) begin
            chk("sb_has_entry", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    K_DONE:  begin ec1 = 4; eb1 = 1; ec2 = 2; eb2 = 1; end
                    K_FAULT: begin ec1 = 1; eb1 = 1; ec2 = 1; eb2 = 1; end
                    default: begin ec1 = 0; eb1 = 1; ec2 = 7; eb2 = 0; end
                endcase
                chk({e.name, "_color1"},  int'(color1),  ec1);
                chk({e.name, "_bright1"}, int'(bright1), eb1);
                chk({e.name, "_color2"},  int'(color2),  ec2);
                chk({e.name, "_bright2"}, int'(bright2), eb2);
                chk({e.name, "_react_ms"}, int'(react_ms), e.react);
                chk({e.name, "_early_fault"}, int'(early_fault), e.early);
                chk({e.name, "_result_valid"}, int'(result_valid),
                    (e.kind == K_DONE) ? 1 : 0);
                chk({e.name, "_armed_cycles"}, armed_cnt, e.armed);
                chk({e.name, "_go_cycles"}, go_cnt, e.go);
                if (e.kind == K_DONE) rv_follow = 1;
            end
        end
        prev_busy = b;
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start_btn = 1'b1;
        @(posedge clk);
        #1 start_btn = 1'b0;
    endtask

    task automatic pulse_resp();
        #1 resp_btn = 1'b1;
        @(posedge clk);
        #1 resp_btn = 1'b0;
    endtask

    // Returns at the negedge of the first GO cycle (k = 0).
    task automatic wait_go(input string name);
        int found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (color1 == 3'b010 && bright1 == 1'b1) found = 1;
        end
        if (found == 0) chk({name, "_reached_go"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (busy === 1'b0) found = 1;
        end
        if (found == 0) chk({name, "_left_busy"}, 0, 1);
        repeat (3) @(negedge clk);
    endtask

    // Called at the negedge of GO cycle 0; resp is sampled at the end of cycle k.
    task automatic resp_at(input int k);
        repeat (k) @(posedge clk);
        pulse_resp();
    endtask

    initial begin
        rst       = 1'b1;
        start_btn = 1'b0;
        resp_btn  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: idle outputs after reset
        repeat (20) @(negedge clk);
        chk("idle_color1",  int'(color1),  0);
        chk("idle_bright1", int'(bright1), 1);
        chk("idle_color2",  int'(color2),  7);
        chk("idle_bright2", int'(bright2), 0);
        chk("idle_react",   int'(react_ms), 0);
        chk("idle_busy",    int'(busy), 0);
        chk("idle_rv",      int'(result_valid), 0);
        chk("idle_early",   int'(early_fault), 0);

        // 2: normal game, response at k = 37
        push("t2_done", K_DONE, 3, 0, 50, 38);
        pulse_start();
        wait_go("t2");
        resp_at(37);
        wait_idle("t2");

        // 3: early press 20 cycles into ARMED
        push("t3_early", K_FAULT, 0, 1, 21, 0);
        pulse_start();
        repeat (20) @(posedge clk);
        pulse_resp();
        wait_idle("t3");

        // 4a: no response, timeout after 200 GO cycles
        push("t4_timeout", K_FAULT, 20, 0, 50, 200);
        pulse_start();
        wait_go("t4a");
        wait_idle("t4a");

        // 4b: response on the exact timeout edge
        push("t4_edge", K_DONE, 20, 0, 50, 200);
        pulse_start();
        wait_go("t4b");
        resp_at(199);
        wait_idle("t4b");

        // 5: reset 30 cycles into ARMED, then a full fresh game
        push("t5_reset", K_IDLE, 0, 0, 31, 0);
        pulse_start();
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle("t5a");
        push("t5_after", K_DONE, 1, 0, 50, 16);
        pulse_start();
        wait_go("t5b");
        resp_at(15);
        wait_idle("t5b");

        // 6: start+resp in IDLE arms; start during GO ignored
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        push("t6_game", K_DONE, 2, 0, 50, 26);
        @(posedge clk);
        #1 begin start_btn = 1'b1; resp_btn = 1'b1; end
        @(posedge clk);
        #1 begin start_btn = 1'b0; resp_btn = 1'b0; end
        wait_go("t6");
        repeat (10) @(posedge clk);
        #1 start_btn = 1'b1;
        @(posedge clk);
        #1 start_btn = 1'b0;
        repeat (14) @(posedge clk);
        pulse_resp();
        wait_idle("t6");

        // 6: start in DONE restarts directly and clears react_ms
        push("t6_restart", K_FAULT, 20, 0, 50, 200);
        pulse_start();
        @(negedge clk);
        chk("t6_restart_react_cleared", int'(react_ms), 0);
        chk("t6_restart_busy", int'(busy), 1);
        wait_idle("t6r");

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
